uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
Framing controller that sits directly behind the byte-level UART receiver. It consumes the receiver's rx_data/rx_done byte strobes and assembles framed messages into a local payload buffer. Each frame is SOF, LEN, LEN payload bytes, then CHK. The controller validates length, checksum and inter-byte timing, then holds a good frame for the downstream consumer until it is acknowledged.

Parameters:
CLK_FREQ, 27000000, system clock frequency in Hz
BAUD_RATE, 115200, UART line rate; used only for the timeout computation
MAX_LEN, 16, maximum payload length in bytes (power of 2, 2..256)
SOF_BYTE, 8'hA5, start-of-frame marker
TIMEOUT_BYTES, 4, maximum inter-byte gap in byte times (10 bit periods each)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
rx_data  input  8  received byte from the UART receiver
rx_done  input  1  one-cycle strobe; rx_data is valid in the same cycle
frame_valid  output  1  a complete, checked frame is held in the buffer
frame_len  output  clog2(MAX_LEN+1)  payload length of the held frame
rd_addr  input  clog2(MAX_LEN)  payload read index
rd_data  output  8  payload byte at rd_addr, registered, one-cycle latency
frame_ack  input  1  consumer releases the held frame
err_len  output  1  one-cycle pulse: LEN is 0 or greater than MAX_LEN
err_chk  output  1  one-cycle pulse: checksum mismatch
err_timeout  output  1  one-cycle pulse: inter-byte gap exceeded
err_overrun  output  1  one-cycle pulse: byte arrived while a frame was held

Behaviour:
- Reset is asynchronous. All outputs reset to 0; state resets to IDLE; all counters reset to 0.
- The buffer contents are not reset and are undefined until the first write.
- States and transitions:
  - IDLE: on rx_done with rx_data==SOF_BYTE, go to LEN. All other bytes are discarded silently.
  - LEN: on rx_done:
    - If the byte is 0 or greater than MAX_LEN: pulse err_len, go to IDLE.
    - Otherwise: latch len, set chk = byte, clear the index, go to PAYLOAD.
  - PAYLOAD: on rx_done, write buf[idx] = byte, chk ^= byte, idx++. When idx reaches len, go to CHK. SOF_BYTE inside the payload is ordinary data.
  - CHK: on rx_done:
    - If byte == chk: go to HOLD; frame_len = len; frame_valid=1 on the cycle after this rx_done.
    - Otherwise: pulse err_chk, go to IDLE.
  - HOLD: frame_valid stays 1.
    - frame_ack → frame_valid=0 on the next cycle, go to IDLE.
    - rx_done → pulse err_overrun; the byte is discarded and the buffer is not modified.
    - frame_ack and rx_done in the same cycle: err_overrun pulses, the byte is discarded, go to IDLE.
    - frame_ack outside HOLD is ignored.
- Checksum: 8-bit XOR of LEN and all payload bytes.
- Timeout:
  - Limit = TIMEOUT_BYTES*10*(CLK_FREQ/BAUD_RATE) clocks; counter is 32 bits.
  - The counter runs only in LEN, PAYLOAD and CHK, and clears on every rx_done and on every state entry.
  - On reaching the limit: pulse err_timeout, go to IDLE. A partially written buffer is not exposed.
- rx_done coinciding with timeout expiry: the byte is processed and the timeout does not fire.
- Error pulses are mutually exclusive, each exactly 1 cycle, and registered.
- rd_data = buf[rd_addr] registered every cycle. Reads are legal in any state but are only meaningful while frame_valid=1.
- frame_len holds its value until the next frame is accepted.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, LEN, PAYLOAD, CHK, HOLD)
  - SOF_BYTE default
  - a DIV_CNT = CLK_FREQ/BAUD_RATE helper shared with the receiver and transmitter
- One natural sub-module: uart_frame_buf, a MAX_LEN x 8 single-write, registered-read RAM.

Test Plan:
- Bytes A5 03 11 22 33 03 (CHK = 03^11^22^33 = 03) → frame_valid=1 one cycle after the last rx_done, frame_len=3; reading addr 0,1,2 returns 11,22,33 with 1-cycle latency; frame_ack → frame_valid=0 next cycle.
- A5 02 10 20 00 (expected CHK 32) → err_chk single pulse, frame_valid stays 0; a following good frame is accepted.
- A5 00, then A5 11 (MAX_LEN=16) → err_len pulses twice; state returns to IDLE both times.
- A5 02 10, then no bytes for TIMEOUT_BYTES*10*234 clocks → err_timeout at exactly that count; no frame_valid.
- Held frame, then byte 55 without ack → err_overrun pulse, buffer unchanged; frame_ack and rx_done in the same cycle → overrun pulse and return to IDLE.
- Assert rst_n low mid-PAYLOAD → all outputs 0; a complete frame sent afterwards is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, default SOF marker and the
// clocks-per-bit helper also used by the byte receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_HOLD
    } frame_state_t;

    localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

    function automatic int div_cnt(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    localparam int DIV_CNT = div_cnt(27000000, 115200);

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: one write port, one registered read port. Storage is not
// reset; only the read register is.
module uart_frame_buf
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame assembler behind the UART byte receiver: SOF, LEN, payload, XOR
// checksum; holds a good frame until the consumer acknowledges it.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | hunting for SOF, other bytes dropped silently
// ST_LEN     | waiting for the length byte
// ST_PAYLOAD | writing payload bytes into the buffer
// ST_CHK     | waiting for the checksum byte
// ST_HOLD    | good frame exposed, waiting for frame_ack
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int         CLK_FREQ      = 27000000,
    parameter int         BAUD_RATE     = 115200,
    parameter int         MAX_LEN       = 16,
    parameter logic [7:0] SOF_BYTE      = SOF_BYTE_DEFAULT,
    parameter int         TIMEOUT_BYTES = 4,
    localparam int        LEN_W         = $clog2(MAX_LEN + 1),
    localparam int        ADDR_W        = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic              frame_valid,
    output logic [LEN_W-1:0]  frame_len,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    input  logic              frame_ack,
    output logic              err_len,
    output logic              err_chk,
    output logic              err_timeout,
    output logic              err_overrun
);

    localparam logic [31:0] TMO_LIMIT =
        32'(TIMEOUT_BYTES * 10 * div_cnt(CLK_FREQ, BAUD_RATE));
    localparam logic [8:0]  MAX_LEN_9 = 9'(MAX_LEN);

    frame_state_t      state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic [7:0]        chk_q;
    logic [31:0]       tmo_cnt;

    logic              tmo_run;
    logic              tmo_hit;
    logic              len_bad;
    logic              buf_we;

    assign tmo_run = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
    // A byte landing on the expiry cycle wins over the timeout.
    assign tmo_hit = tmo_run && !rx_done && (tmo_cnt == TMO_LIMIT - 32'd1);
    assign len_bad = (rx_data == 8'h00) || ({1'b0, rx_data} > MAX_LEN_9);
    assign buf_we  = (state == ST_PAYLOAD) && rx_done;

    uart_frame_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (buf_we),
        .wr_addr (idx_q[ADDR_W-1:0]),
        .wr_data (rx_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            chk_q       <= 8'h00;
            tmo_cnt     <= 32'd0;
            frame_valid <= 1'b0;
            frame_len   <= '0;
            err_len     <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_len     <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (rx_done && rx_data == SOF_BYTE) begin
                        state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (rx_done) begin
                        if (len_bad) begin
                            err_len <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            len_q <= LEN_W'(rx_data);
                            chk_q <= rx_data;
                            idx_q <= '0;
                            state <= ST_PAYLOAD;
                        end
                    end else if (tmo_hit) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_done) begin
                        chk_q <= chk_q ^ rx_data;
                        idx_q <= idx_q + LEN_W'(1);
                        if ((idx_q + LEN_W'(1)) == len_q) begin
                            state <= ST_CHK;
                        end
                    end else if (tmo_hit) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_CHK: begin
                    if (rx_done) begin
                        if (rx_data == chk_q) begin
                            frame_valid <= 1'b1;
                            frame_len   <= len_q;
                            state       <= ST_HOLD;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end else if (tmo_hit) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (rx_done) begin
                        err_overrun <= 1'b1;
                    end
                    if (frame_ack) begin
                        frame_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Idle in IDLE/HOLD; restarts on every byte and on expiry.
            if (tmo_run && !rx_done && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end else begin
                tmo_cnt <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed frames plus randomized
// frames judged by a frame-level model (length rule, XOR checksum, payload copy).
module tb_uart_rx_frame_ctrl;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 4 * 10 * (27000000 / 115200);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       frame_ack = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic       frame_valid;
    logic [4:0] frame_len;
    logic [7:0] rd_data;
    logic       err_len, err_chk, err_timeout, err_overrun;

    uart_rx_frame_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .frame_valid (frame_valid),
        .frame_len   (frame_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ack   (frame_ack),
        .err_len     (err_len),
        .err_chk     (err_chk),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_len = 0, n_chk = 0, n_tmo = 0, n_ovr = 0;
    int s_len, s_chk, s_tmo, s_ovr;
    logic [3:0] errs;
    logic [3:0] prev_errs = 4'b0;
    logic [7:0] tx_q[$];
    logic [7:0] exp_buf [MAX_LEN];
    logic [7:0] pl [MAX_LEN];

    // Error pulse tally: each pulse one-hot across the four flags and one cycle wide.
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            errs = {err_len, err_chk, err_timeout, err_overrun};
            if (errs != 4'b0) begin
                checks++;
                assert ($onehot(errs) && ((errs & prev_errs) == 4'b0)) else begin
                    errors++;
                    $error("FAIL err_pulse_shape: observed %b (prev %b) expected one-hot single-cycle", errs, prev_errs);
                end
                n_len += 32'(err_len);
                n_chk += 32'(err_chk);
                n_tmo += 32'(err_timeout);
                n_ovr += 32'(err_overrun);
            end
            prev_errs = errs;
        end else begin
            prev_errs = 4'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_len = n_len; s_chk = n_chk; s_tmo = n_tmo; s_ovr = n_ovr;
    endtask

    task automatic expect_errs(input string tag, input int dl, input int dc, input int dt, input int dovr);
        check({tag, "_err_len"},     32'(n_len - s_len), 32'(dl));
        check({tag, "_err_chk"},     32'(n_chk - s_chk), 32'(dc));
        check({tag, "_err_timeout"}, 32'(n_tmo - s_tmo), 32'(dt));
        check({tag, "_err_overrun"}, 32'(n_ovr - s_ovr), 32'(dovr));
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_q(input bit gaps);
        for (int i = 0; i < tx_q.size(); i++) begin
            if (gaps && i > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(tx_q[i]);
        end
        tx_q.delete();
    endtask

    task automatic rd_check(input string tag, input int addr, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = 4'(addr);
        @(negedge clk);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic ack_plain(input string tag);
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check({tag, "_ack_valid"}, 32'(frame_valid), 0);
    endtask

    task automatic ack_with_byte(input string tag);
        snap();
        @(negedge clk);
        frame_ack = 1'b1;
        rx_data   = 8'($urandom);
        rx_done   = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        rx_done   = 1'b0;
        check({tag, "_ackrx_valid"}, 32'(frame_valid), 0);
        expect_errs({tag, "_ackrx"}, 0, 0, 0, 1);
    endtask

    // Frame-level model: build a frame of the requested kind and judge the result.
    task automatic run_random(input int kind);
        int len;
        logic [7:0] c, g;
        len = 0;
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
            do g = 8'($urandom); while (g == 8'hA5);
            tx_q.push_back(g);
        end
        if ($urandom_range(0, 3) == 0) begin
            @(negedge clk); frame_ack = 1'b1;
            @(negedge clk); frame_ack = 1'b0;
        end
        tx_q.push_back(8'hA5);
        if (kind == 2) begin
            c = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
            tx_q.push_back(c);
            snap();
            send_q(1'b1);
            expect_errs("rnd_badlen", 1, 0, 0, 0);
            check("rnd_badlen_valid", 32'(frame_valid), 0);
            return;
        end
        len = $urandom_range(1, MAX_LEN);
        tx_q.push_back(8'(len));
        c = 8'(len);
        for (int i = 0; i < len; i++) begin
            pl[i] = 8'($urandom);
            c ^= pl[i];
            tx_q.push_back(pl[i]);
        end
        if (kind == 1) c ^= 8'($urandom_range(1, 255));
        tx_q.push_back(c);
        snap();
        send_q(1'b1);
        if (kind == 1) begin
            expect_errs("rnd_badchk", 0, 1, 0, 0);
            check("rnd_badchk_valid", 32'(frame_valid), 0);
            return;
        end
        expect_errs("rnd_good", 0, 0, 0, 0);
        check("rnd_good_valid", 32'(frame_valid), 1);
        check("rnd_good_len", 32'(frame_len), 32'(len));
        for (int i = 0; i < len; i++) exp_buf[i] = pl[i];
        for (int i = 0; i < len; i++) rd_check("rnd_rd", i, exp_buf[i]);
        if ($urandom_range(0, 2) == 0) begin
            snap();
            send_byte(8'($urandom));
            expect_errs("rnd_ovr", 0, 0, 0, 1);
            check("rnd_ovr_valid", 32'(frame_valid), 1);
            rd_check("rnd_ovr_rd", len - 1, exp_buf[len - 1]);
        end
        if ($urandom_range(0, 1) == 0) ack_plain("rnd");
        else ack_with_byte("rnd");
    endtask

    task automatic expect_timeout(input string tag);
        int k;
        int t0;
        k  = 0;
        t0 = n_tmo;
        while (n_tmo == t0 && k < TMO + 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_cycles"}, 32'(k), 32'(TMO));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(frame_valid), 0);
        check("rst_len", 32'(frame_len), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_errs", 32'({err_len, err_chk, err_timeout, err_overrun}), 0);
        rst_n = 1'b1;

        // Basic good frame with exact acceptance latency.
        tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        snap();
        send_q(1'b0);
        check("d1_valid", 32'(frame_valid), 1);
        check("d1_len", 32'(frame_len), 3);
        expect_errs("d1", 0, 0, 0, 0);
        rd_check("d1_rd0", 0, 8'h11);
        rd_check("d1_rd1", 1, 8'h22);
        rd_check("d1_rd2", 2, 8'h33);
        ack_plain("d1");

        // Bad checksum, then a good frame.
        tx_q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        snap();
        send_q(1'b1);
        expect_errs("d2", 0, 1, 0, 0);
        check("d2_valid", 32'(frame_valid), 0);
        tx_q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
        send_q(1'b1);
        check("d2b_valid", 32'(frame_valid), 1);
        check("d2b_len", 32'(frame_len), 2);
        ack_plain("d2b");

        // Length 0 and 17 rejected; SOF re-hunted each time.
        tx_q = '{8'hA5, 8'h00, 8'hA5, 8'h11};
        snap();
        send_q(1'b1);
        expect_errs("d3", 2, 0, 0, 0);
        tx_q = '{8'hA5, 8'h10};
        send_q(1'b1);
        for (int i = 0; i < 16; i++) tx_q.push_back(8'(i));
        tx_q.push_back(8'h10);
        send_q(1'b1);
        check("d3_maxlen_valid", 32'(frame_valid), 1);
        check("d3_maxlen_len", 32'(frame_len), 16);
        rd_check("d3_rd15", 15, 8'h0F);
        ack_plain("d3");

        // Inter-byte timeout mid payload.
        tx_q = '{8'hA5, 8'h02, 8'h10};
        snap();
        send_q(1'b0);
        expect_timeout("d4_tmo");
        expect_errs("d4", 0, 0, 1, 0);
        check("d4_valid", 32'(frame_valid), 0);

        // Byte on the last cycle before expiry is accepted.
        tx_q = '{8'hA5, 8'h02};
        send_q(1'b0);
        snap();
        repeat (TMO - 2) @(negedge clk);
        tx_q = '{8'h10, 8'h20, 8'h32};
        send_q(1'b0);
        expect_errs("d5", 0, 0, 0, 0);
        check("d5_valid", 32'(frame_valid), 1);

        // Overrun while held: buffer untouched; then ack coinciding with a byte.
        snap();
        send_byte(8'h55);
        expect_errs("d6", 0, 0, 0, 1);
        check("d6_valid", 32'(frame_valid), 1);
        rd_check("d6_rd0", 0, 8'h10);
        rd_check("d6_rd1", 1, 8'h20);
        ack_with_byte("d6");

        // Reset mid payload.
        tx_q = '{8'hA5, 8'h05, 8'h01, 8'h02};
        send_q(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("d7_rst_valid", 32'(frame_valid), 0);
        check("d7_rst_len", 32'(frame_len), 0);
        check("d7_rst_rd", 32'(rd_data), 0);
        check("d7_rst_errs", 32'({err_len, err_chk, err_timeout, err_overrun}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_q = '{8'hA5, 8'h03, 8'hA5, 8'h5A, 8'h00, 8'hFC};
        snap();
        send_q(1'b1);
        expect_errs("d7", 0, 0, 0, 0);
        check("d7_valid", 32'(frame_valid), 1);
        check("d7_len", 32'(frame_len), 3);
        rd_check("d7_rd0", 0, 8'hA5);
        rd_check("d7_rd1", 1, 8'h5A);
        ack_plain("d7");

        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(0, 9);
            run_random(r < 6 ? 0 : (r < 8 ? 1 : 2));
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
